// File: rtl/pipelined_control_unit.sv
// Decode control unit feeding the ID/EX register, with stall/flush and MULT/DIV busy tracking.
// Optional ILLEGAL_TRAP_EN macro adds illegal_e trapping of unknown instructions.
module pipelined_control_unit #(
  parameter int OP_BITS    = 6,
  parameter int FUNCT_BITS = 6,
  parameter int MULDIV_LAT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_d,
  input  logic [OP_BITS-1:0]    op_code,
  input  logic [FUNCT_BITS-1:0] funct,
  input  logic                  stall_in,
  input  logic                  flush_e,
  output logic                  stall_d,
  output logic                  valid_e,
  output logic                  reg_write_e,
  output logic                  mem_write_e,
  output logic                  alu_src_e,
  output logic                  ext_op_e,
  output logic                  branch_e,
  output logic                  jump_e,
  output logic                  md_start_e,
  output logic [1:0]            reg_dst_e,
  output logic [1:0]            mem_to_reg_e,
  output logic [1:0]            alu_control_e,
  output logic [FUNCT_BITS-1:0] funct_e,
  output logic                  md_busy
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                  illegal_e
`endif
);

  localparam logic [OP_BITS-1:0] OP_ROP  = OP_BITS'(6'h00);
  localparam logic [OP_BITS-1:0] OP_LW   = OP_BITS'(6'h23);
  localparam logic [OP_BITS-1:0] OP_SW   = OP_BITS'(6'h2B);
  localparam logic [OP_BITS-1:0] OP_BEQ  = OP_BITS'(6'h04);
  localparam logic [OP_BITS-1:0] OP_ADDI = OP_BITS'(6'h08);
  localparam logic [OP_BITS-1:0] OP_ANDI = OP_BITS'(6'h0C);
  localparam logic [OP_BITS-1:0] OP_ORI  = OP_BITS'(6'h0D);
  localparam logic [OP_BITS-1:0] OP_J    = OP_BITS'(6'h02);
  localparam logic [OP_BITS-1:0] OP_JAL  = OP_BITS'(6'h03);

  localparam logic [FUNCT_BITS-1:0] F_MULT = FUNCT_BITS'(6'h18);
  localparam logic [FUNCT_BITS-1:0] F_DIV  = FUNCT_BITS'(6'h1A);
  localparam logic [FUNCT_BITS-1:0] F_MFHI = FUNCT_BITS'(6'h10);
  localparam logic [FUNCT_BITS-1:0] F_MFLO = FUNCT_BITS'(6'h12);

  localparam int CW = $clog2(MULDIV_LAT) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MULDIV_LAT - 1);

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_write;
    logic                  alu_src;
    logic                  ext_op;
    logic                  branch;
    logic                  jump;
    logic                  md_start;
    logic [1:0]            reg_dst;
    logic [1:0]            mem_to_reg;
    logic [1:0]            alu_ctl;
    logic [FUNCT_BITS-1:0] funct;
`ifdef ILLEGAL_TRAP_EN
    logic                  illegal;
`endif
  } ctl_t;

  typedef enum logic {IDLE, BUSY} md_state_t;

  ctl_t      d, q;
  md_state_t state;
  logic [CW-1:0] cnt;

  logic is_rop, is_lw, is_sw, is_beq, is_addi;
  logic is_andi, is_ori, is_j, is_jal;
  logic is_md, is_dep, md_issue, md_dep, md_stall;

  assign is_rop  = op_code == OP_ROP;
  assign is_lw   = op_code == OP_LW;
  assign is_sw   = op_code == OP_SW;
  assign is_beq  = op_code == OP_BEQ;
  assign is_addi = op_code == OP_ADDI;
  assign is_andi = op_code == OP_ANDI;
  assign is_ori  = op_code == OP_ORI;
  assign is_j    = op_code == OP_J;
  assign is_jal  = op_code == OP_JAL;

  assign is_md    = (funct == F_MULT) || (funct == F_DIV);
  assign is_dep   = is_md || (funct == F_MFHI) || (funct == F_MFLO);
  assign md_issue = valid_d && is_rop && is_md;
  assign md_dep   = valid_d && is_rop && is_dep;
  assign md_stall = md_dep && (state == BUSY);
  assign stall_d  = stall_in || md_stall;
  assign md_busy  = state == BUSY;

`ifdef ILLEGAL_TRAP_EN
  localparam logic [FUNCT_BITS-1:0] F_ADD = FUNCT_BITS'(6'h20);
  localparam logic [FUNCT_BITS-1:0] F_SUB = FUNCT_BITS'(6'h22);
  localparam logic [FUNCT_BITS-1:0] F_AND = FUNCT_BITS'(6'h24);
  localparam logic [FUNCT_BITS-1:0] F_OR  = FUNCT_BITS'(6'h25);
  localparam logic [FUNCT_BITS-1:0] F_SLT = FUNCT_BITS'(6'h2A);

  logic known_op, legal_funct, illegal;

  assign known_op = is_rop || is_lw || is_sw || is_beq || is_addi ||
                    is_andi || is_ori || is_j || is_jal;
  assign legal_funct = is_dep || (funct == F_ADD) ||
                       (funct == F_SUB) || (funct == F_AND) ||
                       (funct == F_OR) || (funct == F_SLT);
  assign illegal = !known_op || (is_rop && !legal_funct);
`endif

  always_comb begin
    d       = '0;
    d.valid = 1'b1;
    d.funct = funct;
    unique case (1'b1)
      is_rop: begin
        d.reg_dst   = 2'b01;
        d.reg_write = !is_md;
        d.alu_ctl   = 2'b10;
        d.md_start  = is_md;
      end
      is_lw: begin
        d.alu_src    = 1'b1;
        d.mem_to_reg = 2'b01;
        d.reg_write  = 1'b1;
        d.ext_op     = 1'b1;
      end
      is_sw: begin
        d.alu_src   = 1'b1;
        d.mem_write = 1'b1;
        d.ext_op    = 1'b1;
      end
      is_beq: begin
        d.alu_ctl = 2'b01;
        d.branch  = 1'b1;
        d.ext_op  = 1'b1;
      end
      is_addi: begin
        d.alu_src   = 1'b1;
        d.reg_write = 1'b1;
        d.ext_op    = 1'b1;
      end
      is_andi || is_ori: begin
        d.alu_src   = 1'b1;
        d.reg_write = 1'b1;
        d.alu_ctl   = 2'b10;
      end
      is_j: d.jump = 1'b1;
      is_jal: begin
        d.jump       = 1'b1;
        d.reg_write  = 1'b1;
        d.reg_dst    = 2'b10;
        d.mem_to_reg = 2'b10;
      end
      default: ;
    endcase
    if (!valid_d) begin
      d = '0;
`ifdef ILLEGAL_TRAP_EN
    end else if (illegal) begin
      d         = '0;
      d.valid   = 1'b1;
      d.illegal = 1'b1;
`endif
    end
  end

  // A held (stalled) D instruction leaves a bubble in E.
  always_ff @(posedge clk) begin
    if (reset) begin
      q     <= '0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      if (flush_e || stall_d) q <= '0;
      else q <= d;
      unique case (state)
        IDLE: begin
          if (md_issue && !flush_e && !stall_d) begin
            state <= BUSY;
            cnt   <= CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt == '0) state <= IDLE;
          else cnt <= cnt - CW'(1);
        end
      endcase
    end
  end

  assign valid_e       = q.valid;
  assign reg_write_e   = q.reg_write;
  assign mem_write_e   = q.mem_write;
  assign alu_src_e     = q.alu_src;
  assign ext_op_e      = q.ext_op;
  assign branch_e      = q.branch;
  assign jump_e        = q.jump;
  assign md_start_e    = q.md_start;
  assign reg_dst_e     = q.reg_dst;
  assign mem_to_reg_e  = q.mem_to_reg;
  assign alu_control_e = q.alu_ctl;
  assign funct_e       = q.funct;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_e     = q.illegal;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench for pipelined_control_unit (MULDIV_LAT = 4).
// Driver queues hand-computed E/stall/busy expectations; monitor pops and compares.
module tb_pipelined_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_d = 1'b0;
  logic [5:0] op_code = '0;
  logic [5:0] funct = '0;
  logic       stall_in = 1'b0;
  logic       flush_e = 1'b0;
  logic       stall_d, valid_e, reg_write_e, mem_write_e;
  logic       alu_src_e, ext_op_e, branch_e, jump_e, md_start_e;
  logic [1:0] reg_dst_e, mem_to_reg_e, alu_control_e;
  logic [5:0] funct_e;
  logic       md_busy;
  logic       ill_act;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_e;
  assign ill_act = illegal_e;
  localparam logic ILL = 1'b1;
`else
  assign ill_act = 1'b0;
  localparam logic ILL = 1'b0;
`endif

  always #5 clk = ~clk;

  pipelined_control_unit #(
    .OP_BITS(6), .FUNCT_BITS(6), .MULDIV_LAT(4)
  ) dut (
    .clk(clk), .reset(reset), .valid_d(valid_d),
    .op_code(op_code), .funct(funct),
    .stall_in(stall_in), .flush_e(flush_e),
    .stall_d(stall_d), .valid_e(valid_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .alu_src_e(alu_src_e), .ext_op_e(ext_op_e),
    .branch_e(branch_e), .jump_e(jump_e),
    .md_start_e(md_start_e), .reg_dst_e(reg_dst_e),
    .mem_to_reg_e(mem_to_reg_e),
    .alu_control_e(alu_control_e),
    .funct_e(funct_e), .md_busy(md_busy)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_e(illegal_e)
`endif
  );

  typedef struct {
    string       name;
    logic [20:0] e;
    logic        busy;
    logic        stall;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic logic [20:0] b(
    input logic v, rw, mw, as, ext, br, j, ms,
    input logic [1:0] rd, mtr, alu,
    input logic [5:0] fn, input logic il);
    return {v, rw, mw, as, ext, br, j, ms, rd, mtr, alu, fn, il};
  endfunction

  task automatic step(input string n, input logic rst, v,
                      input logic [5:0] op, fn,
                      input logic si, fl,
                      input logic [20:0] e,
                      input logic busy, stall);
    exp_t x;
    @(posedge clk);
    #2;
    reset = rst; valid_d = v; op_code = op; funct = fn;
    stall_in = si; flush_e = fl;
    x.name = n; x.e = e; x.busy = busy; x.stall = stall;
    sb.push_back(x);
  endtask

  initial begin : monitor
    logic        s;
    logic [20:0] act;
    exp_t        x;
    forever begin
      @(negedge clk);
      s = stall_d;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        act = {valid_e, reg_write_e, mem_write_e, alu_src_e,
               ext_op_e, branch_e, jump_e, md_start_e,
               reg_dst_e, mem_to_reg_e, alu_control_e,
               funct_e, ill_act};
        checks += 3;
        if (act !== x.e) begin
          failures++;
          $display("FAIL %s ebundle got=%h want=%h", x.name, act, x.e);
        end
        if (md_busy !== x.busy) begin
          failures++;
          $display("FAIL %s md_busy got=%b want=%b", x.name, md_busy, x.busy);
        end
        if (s !== x.stall) begin
          failures++;
          $display("FAIL %s stall_d got=%b want=%b", x.name, s, x.stall);
        end
      end
    end
  end

  localparam logic [20:0] Z = '0;

  initial begin : driver
    logic [20:0] lw, jal, ori, beq, mult, add, mflo;
    logic [20:0] sw, bad, addi, jmp, div;
    lw   = b(1,1,0,1,1,0,0,0,2'b00,2'b01,2'b00,6'h00,0);
    jal  = b(1,1,0,0,0,0,1,0,2'b10,2'b10,2'b00,6'h00,0);
    ori  = b(1,1,0,1,0,0,0,0,2'b00,2'b00,2'b10,6'h00,0);
    beq  = b(1,0,0,0,1,1,0,0,2'b00,2'b00,2'b01,6'h00,0);
    mult = b(1,0,0,0,0,0,0,1,2'b01,2'b00,2'b10,6'h18,0);
    add  = b(1,1,0,0,0,0,0,0,2'b01,2'b00,2'b10,6'h20,0);
    mflo = b(1,1,0,0,0,0,0,0,2'b01,2'b00,2'b10,6'h12,0);
    sw   = b(1,0,1,1,1,0,0,0,2'b00,2'b00,2'b00,6'h00,0);
    bad  = b(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,6'h00,ILL);
    addi = b(1,1,0,1,1,0,0,0,2'b00,2'b00,2'b00,6'h00,0);
    jmp  = b(1,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,6'h00,0);
    div  = b(1,0,0,0,0,0,0,1,2'b01,2'b00,2'b10,6'h1A,0);

    step("rst1",   1,1,6'h23,6'h00,0,0, Z,   0,0);
    step("rst2",   1,1,6'h23,6'h00,0,0, Z,   0,0);
    step("lw",     0,1,6'h23,6'h00,0,0, lw,  0,0);
    step("jal",    0,1,6'h03,6'h00,0,0, jal, 0,0);
    step("ori",    0,1,6'h0D,6'h00,0,0, ori, 0,0);
    step("beq",    0,1,6'h04,6'h00,0,0, beq, 0,0);
    step("mult",   0,1,6'h00,6'h18,0,0, mult,1,0);
    step("add",    0,1,6'h00,6'h20,0,0, add, 1,0);
    step("mflo_s1",0,1,6'h00,6'h12,0,0, Z,   1,1);
    step("mflo_s2",0,1,6'h00,6'h12,0,0, Z,   1,1);
    step("mflo_s3",0,1,6'h00,6'h12,0,0, Z,   0,1);
    step("mflo",   0,1,6'h00,6'h12,0,0, mflo,0,0);
    step("mult_fl",0,1,6'h00,6'h18,0,1, Z,   0,0);
    step("invalid",0,0,6'h00,6'h20,0,0, Z,   0,0);
    step("sw_st1", 0,1,6'h2B,6'h00,1,0, Z,   0,1);
    step("sw_st2", 0,1,6'h2B,6'h00,1,0, Z,   0,1);
    step("sw_st3", 0,1,6'h2B,6'h00,1,0, Z,   0,1);
    step("sw",     0,1,6'h2B,6'h00,0,0, sw,  0,0);
    step("fl_st",  0,1,6'h2B,6'h00,1,1, Z,   0,1);
    step("op3f",   0,1,6'h3F,6'h00,0,0, bad, 0,0);
    step("addi",   0,1,6'h08,6'h00,0,0, addi,0,0);
    step("j",      0,1,6'h02,6'h00,0,0, jmp, 0,0);
    step("mult2",  0,1,6'h00,6'h18,0,0, mult,1,0);
    step("fl_busy",0,0,6'h00,6'h00,0,1, Z,   1,0);
    step("rst_bsy",1,0,6'h00,6'h00,0,0, Z,   0,0);
    step("div",    0,1,6'h00,6'h1A,0,0, div, 1,0);
    step("mfhi_s", 0,1,6'h00,6'h10,0,0, Z,   1,1);
    step("idle",   0,0,6'h00,6'h00,0,0, Z,   1,0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
